// File: rtl/solar_stepper_drv.sv
// Two-axis (tilt/pan) unipolar stepper driver for the solar tracker.
// A shared prescaler paces steps; each axis runs an OFF/MOVE/HOLD machine.
module solar_stepper_drv #(
    parameter int STEP_DIV   = 1000,
    parameter int HOLD_TICKS = 4,
    parameter int POS_INIT   = 100,
    parameter int POS_MAX    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mn,
    input  logic       ms,
    input  logic       me,
    input  logic       mw,
    output logic [3:0] tilt_coil,
    output logic [3:0] pan_coil,
    output logic [7:0] tilt_pos,
    output logic [7:0] pan_pos,
    output logic       tilt_busy,
    output logic       pan_busy,
    output logic       lim_n,
    output logic       lim_s,
    output logic       lim_e,
    output logic       lim_w,
    output logic [1:0] tilt_state,
    output logic [1:0] pan_state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_MOVE = 2'd1,
        ST_HOLD = 2'd2
    } axis_state_t;

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] DIV_LAST  = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [7:0]    POS_MAX8  = 8'(POS_MAX);
    localparam logic [7:0]    POS_INIT8 = 8'(POS_INIT);

    function automatic logic [3:0] coil_of(input logic [1:0] phase);
        logic [3:0] c;
        case (phase)
            2'd0:    c = 4'b1100;
            2'd1:    c = 4'b0110;
            2'd2:    c = 4'b0011;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    // Step prescaler; held at zero while disabled so re-enable gives a full period.
    logic [PW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = en && (div_cnt == DIV_LAST);

    // Index 0 is tilt (mn up / ms down), index 1 is pan (me up / mw down).
    // Conflicting requests on one axis cancel out.
    logic [1:0] up_req;
    logic [1:0] dn_req;

    assign up_req = {me & ~mw, mn & ~ms};
    assign dn_req = {mw & ~me, ms & ~mn};

    for (genvar g = 0; g < 2; g++) begin : g_axis
        axis_state_t   state_q;
        logic [1:0]    phase_q;
        logic [1:0]    phase_nx;
        logic [HW-1:0] hold_q;
        logic [7:0]    pos_q;
        logic [7:0]    pos_nx;
        logic [3:0]    coil_q;
        logic          busy_q;
        logic          lim_hi_q;
        logic          lim_lo_q;
        logic          step_up;
        logic          step_dn;
        logic          step;

        // Soft limits turn a request into "no request" so position never wraps.
        always_comb begin
            step_up  = up_req[g] && (pos_q != POS_MAX8);
            step_dn  = dn_req[g] && (pos_q != 8'd0);
            step     = step_up || step_dn;
            phase_nx = step_up ? phase_q + 2'd1 : phase_q - 2'd1;
            pos_nx   = step_up ? pos_q + 8'd1 : pos_q - 8'd1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= ST_OFF;
                phase_q  <= 2'd0;
                hold_q   <= '0;
                pos_q    <= POS_INIT8;
                coil_q   <= 4'b0000;
                busy_q   <= 1'b0;
                lim_hi_q <= (POS_INIT8 == POS_MAX8);
                lim_lo_q <= (POS_INIT8 == 8'd0);
            end else if (!en) begin
                // Coils released immediately; position and phase are kept for resume.
                state_q <= ST_OFF;
                hold_q  <= '0;
                coil_q  <= 4'b0000;
                busy_q  <= 1'b0;
            end else if (tick) begin
                if (step) begin
                    state_q  <= ST_MOVE;
                    phase_q  <= phase_nx;
                    pos_q    <= pos_nx;
                    hold_q   <= '0;
                    coil_q   <= coil_of(phase_nx);
                    busy_q   <= 1'b1;
                    lim_hi_q <= (pos_nx == POS_MAX8);
                    lim_lo_q <= (pos_nx == 8'd0);
                end else begin
                    case (state_q)
                        ST_MOVE: begin
                            state_q <= ST_HOLD;
                            hold_q  <= '0;
                            busy_q  <= 1'b0;
                        end
                        ST_HOLD: begin
                            if (hold_q == HOLD_LAST) begin
                                state_q <= ST_OFF;
                                hold_q  <= '0;
                                coil_q  <= 4'b0000;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_OFF;
                            coil_q  <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign tilt_coil  = g_axis[0].coil_q;
    assign tilt_pos   = g_axis[0].pos_q;
    assign tilt_busy  = g_axis[0].busy_q;
    assign lim_n      = g_axis[0].lim_hi_q;
    assign lim_s      = g_axis[0].lim_lo_q;
    assign tilt_state = g_axis[0].state_q;

    assign pan_coil   = g_axis[1].coil_q;
    assign pan_pos    = g_axis[1].pos_q;
    assign pan_busy   = g_axis[1].busy_q;
    assign lim_e      = g_axis[1].lim_hi_q;
    assign lim_w      = g_axis[1].lim_lo_q;
    assign pan_state  = g_axis[1].state_q;

endmodule

// File: tb/tb_solar_stepper_drv.sv
// Bench for solar_stepper_drv: directed vector table, limit/hold sequence,
// and randomized traffic checked every cycle against a tick-level model.
module tb_solar_stepper_drv;

    localparam int STEP_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int POS_INIT   = 100;
    localparam int POS_MAX    = 200;

    logic       clk = 1'b0;
    logic       rst, en, mn, ms, me, mw;
    logic [3:0] tilt_coil, pan_coil;
    logic [7:0] tilt_pos, pan_pos;
    logic       tilt_busy, pan_busy;
    logic       lim_n, lim_s, lim_e, lim_w;
    logic [1:0] tilt_state, pan_state;

    solar_stepper_drv #(
        .STEP_DIV  (STEP_DIV),
        .HOLD_TICKS(HOLD_TICKS),
        .POS_INIT  (POS_INIT),
        .POS_MAX   (POS_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mn        (mn),
        .ms        (ms),
        .me        (me),
        .mw        (mw),
        .tilt_coil (tilt_coil),
        .pan_coil  (pan_coil),
        .tilt_pos  (tilt_pos),
        .pan_pos   (pan_pos),
        .tilt_busy (tilt_busy),
        .pan_busy  (pan_busy),
        .lim_n     (lim_n),
        .lim_s     (lim_s),
        .lim_e     (lim_e),
        .lim_w     (lim_w),
        .tilt_state(tilt_state),
        .pan_state (pan_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [29:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model: pure tick arithmetic over integers
    logic [3:0] coil_tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    int m_en_cycles;
    int m_pos   [2];
    int m_phase [2];
    bit m_moving[2];
    bit m_on    [2];
    int m_hold_left[2];

    task automatic model_step();
        int up[2], dn[2], dir;
        bit tk;
        up[0] = mn; dn[0] = ms; up[1] = me; dn[1] = mw;
        if (rst) begin
            m_en_cycles = 0;
            for (int a = 0; a < 2; a++) begin
                m_pos[a] = POS_INIT; m_phase[a] = 0; m_moving[a] = 0;
                m_on[a] = 0; m_hold_left[a] = 0;
            end
        end else if (!en) begin
            m_en_cycles = 0;
            for (int a = 0; a < 2; a++) begin
                m_moving[a] = 0; m_on[a] = 0;
            end
        end else begin
            tk = (m_en_cycles % STEP_DIV) == STEP_DIV - 1;
            m_en_cycles++;
            if (tk) begin
                for (int a = 0; a < 2; a++) begin
                    dir = up[a] - dn[a];
                    if (dir == 1 && m_pos[a] == POS_MAX) dir = 0;
                    if (dir == -1 && m_pos[a] == 0) dir = 0;
                    if (dir != 0) begin
                        m_pos[a] += dir;
                        m_phase[a] = (m_phase[a] + dir + 4) % 4;
                        m_moving[a] = 1; m_on[a] = 1;
                    end else if (m_moving[a]) begin
                        m_moving[a] = 0; m_hold_left[a] = HOLD_TICKS;
                    end else if (m_on[a]) begin
                        m_hold_left[a]--;
                        if (m_hold_left[a] == 0) m_on[a] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [29:0] model_vec();
        logic [3:0] c0, c1;
        c0 = m_on[0] ? coil_tbl[m_phase[0]] : 4'b0000;
        c1 = m_on[1] ? coil_tbl[m_phase[1]] : 4'b0000;
        return {c0, c1, 8'(m_pos[0]), 8'(m_pos[1]), m_moving[0], m_moving[1],
                m_pos[0] == POS_MAX, m_pos[0] == 0, m_pos[1] == POS_MAX, m_pos[1] == 0};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {tilt_coil, pan_coil, tilt_pos, pan_pos, tilt_busy, pan_busy,
                lim_n, lim_s, lim_e, lim_w};
    endfunction

    // driver: one clock with scoreboard compare after the edge
    task automatic step_cycle();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] req);
        rst = r; en = e; {mn, ms, me, mw} = req;
    endtask

    typedef struct {
        logic       rst, en;
        logic [3:0] req;      // {mn, ms, me, mw}
        int         ncyc;
        logic [7:0] t_pos, p_pos;
        logic [3:0] t_coil, p_coil;
        logic       t_busy, p_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic e, input logic [3:0] req, input int n,
                           input logic [7:0] tp, input logic [7:0] pp,
                           input logic [3:0] tc, input logic [3:0] pc,
                           input logic tb, input logic pb);
        vec_t v;
        v.rst = r; v.en = e; v.req = req; v.ncyc = n;
        v.t_pos = tp; v.p_pos = pp; v.t_coil = tc; v.p_coil = pc;
        v.t_busy = tb; v.p_busy = pb;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'b0000);

        add_vec(1, 0, 4'b0000,  2, 100, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b0000, 40, 100, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  4, 101, 100, 4'b0110, 4'b0000, 1, 0);
        add_vec(0, 1, 4'b1000,  4, 102, 100, 4'b0011, 4'b0000, 1, 0);
        add_vec(0, 1, 4'b1000,  4, 103, 100, 4'b1001, 4'b0000, 1, 0);
        add_vec(0, 1, 4'b0000,  4, 103, 100, 4'b1001, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b0000,  4, 103, 100, 4'b1001, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b0000,  4, 103, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1111, 40, 103, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  8, 105, 100, 4'b0110, 4'b0000, 1, 0);
        add_vec(0, 0, 4'b1000,  1, 105, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 0, 4'b1000,  5, 105, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  3, 105, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  1, 106, 100, 4'b0011, 4'b0000, 1, 0);
        add_vec(0, 1, 4'b1010,  4, 107, 101, 4'b1001, 4'b0110, 1, 1);
        add_vec(1, 1, 4'b1010,  1, 100, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  3, 100, 100, 4'b0000, 4'b0000, 0, 0);
        add_vec(0, 1, 4'b1000,  1, 101, 100, 4'b0110, 4'b0000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].req);
            repeat (vecs[i].ncyc) step_cycle();
            check($sformatf("vec%0d tilt_pos", i),  32'(tilt_pos),  32'(vecs[i].t_pos));
            check($sformatf("vec%0d pan_pos", i),   32'(pan_pos),   32'(vecs[i].p_pos));
            check($sformatf("vec%0d tilt_coil", i), 32'(tilt_coil), 32'(vecs[i].t_coil));
            check($sformatf("vec%0d pan_coil", i),  32'(pan_coil),  32'(vecs[i].p_coil));
            check($sformatf("vec%0d busy", i),      32'({tilt_busy, pan_busy}),
                  32'({vecs[i].t_busy, vecs[i].p_busy}));
            if (i == 1) check("idle limits", 32'({lim_n, lim_s, lim_e, lim_w}), 32'(4'b0000));
        end

        // Drive tilt into the upper limit and pan into the lower limit together.
        drive(1'b1, 1'b0, 4'b0000);
        repeat (2) step_cycle();
        drive(1'b0, 1'b1, 4'b1001);
        repeat (400) step_cycle();
        check("lim pos",    32'({tilt_pos, pan_pos}), 32'({8'd200, 8'd0}));
        check("lim flags",  32'({lim_n, lim_s, lim_e, lim_w}), 32'(4'b1001));
        check("lim busy",   32'({tilt_busy, pan_busy}), 32'(2'b11));
        check("lim coils",  32'({tilt_coil, pan_coil}), 32'({4'b1100, 4'b1100}));
        repeat (4) step_cycle();
        check("blocked busy",  32'({tilt_busy, pan_busy}), 32'(2'b00));
        check("blocked coils", 32'({tilt_coil, pan_coil}), 32'({4'b1100, 4'b1100}));
        check("blocked pos",   32'({tilt_pos, pan_pos}), 32'({8'd200, 8'd0}));
        repeat (8) step_cycle();
        check("limit release coils", 32'({tilt_coil, pan_coil}), 32'(8'h00));
        check("limit flags kept",    32'({lim_n, lim_s, lim_e, lim_w}), 32'(4'b1001));

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 4'b0000);
        repeat (2) step_cycle();
        drive(1'b0, 1'b1, 4'b0000);
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) {mn, ms, me, mw} = 4'($urandom_range(0, 15));
            step_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
